fetch_pc_ctrl: RTL

IF-stage program-counter controller with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It generates the fetch PC every cycle and predicts taken control transfers. It consumes the EX-stage branch resolution (taken flag and ALU target) to detect mispredictions, redirect fetch, flush younger stages and train the BTB. It sits between the EX-stage branch resolution logic and instruction memory.

---
 rtl/fetch_pkg.sv | 47 ++++
 rtl/fetch_pc_ctrl_btb_dm.sv | 107 ++++++++++
 rtl/fetch_pc_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared fetch-stage definitions: BTB entry layout, 2-bit direction
//   counter encodings and helpers, and the RV32 control-transfer opcodes
//   that decode and branch resolution also use.
package fetch_pkg;

  // 2-bit saturating direction counter; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // The tag field is sized for the smallest legal index (30 bits = pc[31:2]).
  // Narrower tags are stored zero-extended in the low bits.
  localparam int unsigned BTB_TAG_MAX_W = 30;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [31:0]              target;
    ctr_e                     ctr;
  } btb_entry_t;

  // Control-transfer opcodes (inst[6:0]).
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic ctr_e ctr_inc(input ctr_e c);
    case (c)
      CTR_SNT: ctr_inc = CTR_WNT;
      CTR_WNT: ctr_inc = CTR_WT;
      default: ctr_inc = CTR_ST;
    endcase
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    case (c)
      CTR_ST:  ctr_dec = CTR_WT;
      CTR_WT:  ctr_dec = CTR_WNT;
      default: ctr_dec = CTR_SNT;
    endcase
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_btb_dm.sv
// btb_dm
//   Direct-mapped branch target buffer with 2-bit direction counters.
//   Lookup port (combinational) predicts for the current fetch PC.
//   Single update port trains, allocates or invalidates the entry indexed
//   by the resolving EX PC. Synchronous active-low reset clears every entry.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   lk_pc_i                lookup PC (fetch PC)
//   lk_taken_o             hit & ctr[1]
//   lk_target_o            predicted target, 0 when not predicted taken
//   upd_en_i               train with a resolved control transfer
//   inv_en_i               invalidate the indexed entry (aliasing)
//   upd_pc_i               PC of the resolving instruction
//   upd_taken_i            resolved direction
//   upd_target_i           resolved target
module btb_dm
  import fetch_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lk_pc_i,
  output logic        lk_taken_o,
  output logic [31:0] lk_target_o,
  input  logic        upd_en_i,
  input  logic        inv_en_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int unsigned NUM_ENT = 1 << IDX_W;

  btb_entry_t mem_q [NUM_ENT];

  logic [IDX_W-1:0]         lk_idx;
  logic [BTB_TAG_MAX_W-1:0] lk_tag;
  btb_entry_t               lk_entry;
  logic                     lk_hit;

  logic [IDX_W-1:0]         upd_idx;
  logic [BTB_TAG_MAX_W-1:0] upd_tag;
  btb_entry_t               upd_cur;
  logic                     upd_hit;

  logic                     wr_en;
  btb_entry_t               wr_entry;

  // Byte-offset bits never participate in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

  // Lookup
  assign lk_idx      = lk_pc_i[IDX_W+1:2];
  assign lk_tag      = BTB_TAG_MAX_W'(lk_pc_i >> (IDX_W + 2));
  assign lk_entry    = mem_q[lk_idx];
  assign lk_hit      = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign lk_taken_o  = lk_hit && lk_entry.ctr[1];
  assign lk_target_o = lk_taken_o ? lk_entry.target : 32'h0;

  // Update: reads the pre-update entry, so a same-cycle lookup of the same
  // index sees old state (no bypass).
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = BTB_TAG_MAX_W'(upd_pc_i >> (IDX_W + 2));
  assign upd_cur = mem_q[upd_idx];
  assign upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = upd_cur;
    if (upd_en_i) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken_i) begin
          wr_entry.ctr    = ctr_inc(upd_cur.ctr);
          wr_entry.target = upd_target_i;
        end else begin
          wr_entry.ctr    = ctr_dec(upd_cur.ctr);
        end
      end else if (upd_taken_i) begin
        wr_en             = 1'b1;
        wr_entry.valid    = 1'b1;
        wr_entry.tag      = upd_tag;
        wr_entry.target   = upd_target_i;
        wr_entry.ctr      = CTR_WT;
      end
    end else if (inv_en_i) begin
      // A non-control instruction was predicted taken: the entry belongs to
      // a different PC sharing this index, so drop it.
      wr_en          = 1'b1;
      wr_entry.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: 32'h0, ctr: CTR_WNT};
      end
    end else if (wr_en) begin
      mem_q[upd_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
//   IF-stage program-counter controller. Generates the fetch PC each cycle,
//   predicts taken control transfers through a direct-mapped BTB, detects
//   mispredictions from the EX-stage resolution, redirects fetch, flushes
//   younger stages and trains the BTB.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   stall_i                hold the fetch PC
//   ex_valid_i             EX holds a valid instruction (one cycle each)
//   ex_is_ctrl_i           EX instruction is B-type / JAL / JALR
//   ex_pc_i                PC of the EX instruction
//   ex_taken_i             resolved PC-select
//   ex_target_i            resolved target
//   ex_pred_taken_i        prediction carried with the EX instruction
//   ex_pred_target_i       predicted target carried with the EX instruction
//   pc_o                   registered fetch PC
//   pred_taken_o           prediction for pc_o (combinational)
//   pred_target_o          predicted target for pc_o, 0 when not taken
//   flush_o                mispredict: kill IF/ID and ID/EX
//   mispred_cnt_o          saturating mispredict counter
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_ctrl_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic [31:0] pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic        flush_o,
  output logic [31:0] mispred_cnt_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;
  logic        mispred;
  logic        btb_upd_en;
  logic        btb_inv_en;

  // A taken prediction to the wrong target is as bad as a wrong direction.
  assign mispred = ex_valid_i &&
                   ((ex_taken_i != ex_pred_taken_i) ||
                    (ex_taken_i && (ex_target_i != ex_pred_target_i)));

  assign btb_upd_en = ex_valid_i && ex_is_ctrl_i;
  assign btb_inv_en = ex_valid_i && !ex_is_ctrl_i && ex_pred_taken_i;

  btb_dm #(
    .IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .lk_pc_i      (pc_q),
    .lk_taken_o   (pred_taken_o),
    .lk_target_o  (pred_target_o),
    .upd_en_i     (btb_upd_en),
    .inv_en_i     (btb_inv_en),
    .upd_pc_i     (ex_pc_i),
    .upd_taken_i  (ex_taken_i),
    .upd_target_i (ex_target_i)
  );

  // Next-PC mux; reset takes precedence in the register itself.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (mispred) begin
      pc_d = ex_taken_i ? ex_target_i : (ex_pc_i + 32'd4);
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (pred_taken_o) begin
      pc_d = pred_target_o;
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (mispred && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      mispred_cnt_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pc_o          = pc_q;
  assign flush_o       = mispred && rst_ni;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule
